// File: rtl/ctest_nios_nios2_gen2_0_cpu_debug_ocimem.sv
// rtl/ctest_nios_nios2_gen2_0_cpu_debug_ocimem.sv - JTAG debug monitor RAM controller
// JTAG commands own the RAM for one or two cycles; the Avalon slave is stalled meanwhile.
module ctest_nios_nios2_gen2_0_cpu_debug_ocimem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_JACC = 2'd1;
  localparam logic [1:0] ST_JCAP = 2'd2;
  localparam int DEPTH = 1 << ADDR_W;

  logic [1:0]        state_q, state_d;
  logic              jpend_q, jpend_d;
  logic              jwr_q, jwr_d;
  logic [31:0]       jdata_q, jdata_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              err_q, err_d;
  logic [31:0]       rd_q, rd_d;
  logic [31:0]       ram [DEPTH];

  logic              any_strobe;
  logic              cpu_wr;
  logic              cpu_rd;
  logic              jacc;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              unused_jdo;

  assign unused_jdo      = ^{jdo[37:36], jdo[2:0]};
  assign avs_waitrequest = (state_q != ST_IDLE) | jpend_q;
  assign MonDReg         = mon_d_q;
  assign monitor_ready   = ~jpend_q;
  assign monitor_error   = err_q;
  assign avs_readdata    = rd_q;

  // The single RAM port belongs to JTAG only while in JACC; otherwise the CPU drives it.
  always_comb begin
    any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    cpu_wr     = avs_write & ~avs_waitrequest;
    cpu_rd     = avs_read & ~avs_write & ~avs_waitrequest;
    jacc       = (state_q == ST_JACC);
    ram_addr   = jacc ? mon_a_q : avs_address;
    ram_wdata  = jacc ? jdata_q : avs_writedata;
    ram_be     = jacc ? {4{jwr_q}} : (cpu_wr ? avs_byteenable : 4'h0);
    ram_re     = (jacc & ~jwr_q) | cpu_rd;
  end

  always_comb begin
    state_d = state_q;
    jpend_d = jpend_q;
    jwr_d   = jwr_q;
    jdata_d = jdata_q;
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    err_d   = err_q;
    rd_d    = ram_re ? ram[ram_addr] : rd_q;

    if (any_strobe) begin
      if (jpend_q) begin
        err_d = 1'b1;
      end else if (take_action_ocimem_b) begin
        jwr_d   = 1'b1;
        jdata_d = jdo[34:3];
        jpend_d = 1'b1;
        state_d = ST_JACC;
      end else if (take_action_ocimem_a) begin
        if (jdo[35]) mon_a_d = jdo[ADDR_W+25:26];
        if (jdo[24]) err_d = 1'b0;
        if (jdo[25]) begin
          jwr_d   = 1'b0;
          jpend_d = 1'b1;
          state_d = ST_JACC;
        end
      end else begin
        jwr_d   = 1'b0;
        jpend_d = 1'b1;
        state_d = ST_JACC;
      end
    end

    case (state_q)
      ST_JACC: begin
        if (jwr_q) begin
          mon_a_d = mon_a_q + 1'b1;
          jpend_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_JCAP;
        end
      end
      ST_JCAP: begin
        mon_d_d = rd_q;
        mon_a_d = mon_a_q + 1'b1;
        jpend_d = 1'b0;
        state_d = ST_IDLE;
      end
      ST_IDLE: ;
      default: begin
        jpend_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      jpend_q <= 1'b0;
      jwr_q   <= 1'b0;
      jdata_q <= '0;
      mon_a_q <= '0;
      mon_d_q <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      jpend_q <= jpend_d;
      jwr_q   <= jwr_d;
      jdata_q <= jdata_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // Writes are suppressed under reset so an abandoned JACC write never lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ctest_nios_nios2_gen2_0_cpu_debug_ocimem.sv
// tb/tb_ctest_nios_nios2_gen2_0_cpu_debug_ocimem.sv - bench for the debug monitor RAM controller
module tb_ctest_nios_nios2_gen2_0_cpu_debug_ocimem;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  ctest_nios_nios2_gen2_0_cpu_debug_ocimem #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level reference: a command occupies the RAM for a fixed number of
  // cycles, after which its effect (RAM update or MonDReg load, address bump) lands.
  logic [31:0] m_mem [256];
  int          busy;
  logic [7:0]  m_mona;
  logic [31:0] m_mond;
  logic        m_err;
  logic [31:0] m_rdata;
  logic        rd_chk;
  logic        p_wr;
  logic [7:0]  p_addr;
  logic [31:0] p_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [37:0] rnd38();
    logic [37:0] v;
    v[31:0]  = $urandom;
    v[37:32] = 6'($urandom);
    return v;
  endfunction

  function automatic logic [37:0] mk_a(input logic ld, input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] v;
    v = rnd38();
    v[35] = ld;
    v[33:26] = a;
    v[25] = rd;
    v[24] = clr;
    return v;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] v;
    v = rnd38();
    v[34:3] = d;
    return v;
  endfunction

  task automatic cyc(input logic rst, input logic sa, input logic sna, input logic sb,
                     input logic [37:0] j, input logic rd, input logic wr,
                     input logic [7:0] ad, input logic [31:0] wd, input logic [3:0] be);
    logic stall;
    reset = rst; take_action_ocimem_a = sa; take_no_action_ocimem_a = sna;
    take_action_ocimem_b = sb; jdo = j; avs_read = rd; avs_write = wr;
    avs_address = ad; avs_writedata = wd; avs_byteenable = be;
    if (rst) begin
      busy = 0; m_mona = 8'h00; m_mond = 32'h0; m_err = 1'b0; m_rdata = 32'h0; rd_chk = 1'b1;
    end else begin
      stall  = (busy > 0);
      rd_chk = 1'b0;
      if (!stall && wr) begin
        for (int i = 0; i < 4; i++) if (be[i]) m_mem[ad][8*i +: 8] = wd[8*i +: 8];
      end else if (!stall && rd) begin
        m_rdata = m_mem[ad];
        rd_chk  = 1'b1;
      end
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          if (p_wr) m_mem[p_addr] = p_data;
          else m_mond = m_mem[p_addr];
          m_mona = p_addr + 8'd1;
        end
      end
      if (sa || sna || sb) begin
        if (stall) m_err = 1'b1;
        else if (sb) begin
          p_wr = 1'b1; p_addr = m_mona; p_data = j[34:3]; busy = 1;
        end else if (sa) begin
          if (j[35]) m_mona = j[33:26];
          if (j[24]) m_err = 1'b0;
          if (j[25]) begin p_wr = 1'b0; p_addr = m_mona; busy = 2; end
        end else begin
          p_wr = 1'b0; p_addr = m_mona; busy = 2;
        end
      end
    end
    @(posedge clk); #1;
    check("ready", {31'b0, monitor_ready}, {31'b0, busy == 0});
    check("waitreq", {31'b0, avs_waitrequest}, {31'b0, busy != 0});
    check("error", {31'b0, monitor_error}, {31'b0, m_err});
    check("mondreg", MonDReg, m_mond);
    if (rd_chk) check("rdata", avs_readdata, m_rdata);
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, rnd38(), 0, 0, 8'($urandom), $urandom, 4'($urandom));
  endtask
  task automatic do_rst();
    cyc(1, 0, 0, 0, rnd38(), 0, 0, 8'h0, 32'h0, 4'h0);
  endtask
  task automatic jt_a(input logic ld, input logic [7:0] a, input logic rd, input logic clr);
    cyc(0, 1, 0, 0, mk_a(ld, a, rd, clr), 0, 0, 8'h0, 32'h0, 4'h0);
  endtask
  task automatic jt_b(input logic [31:0] d);
    cyc(0, 0, 0, 1, mk_b(d), 0, 0, 8'h0, 32'h0, 4'h0);
  endtask
  task automatic jt_na();
    cyc(0, 0, 1, 0, rnd38(), 0, 0, 8'h0, 32'h0, 4'h0);
  endtask
  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    cyc(0, 0, 0, 0, rnd38(), 0, 1, a, d, be);
  endtask
  task automatic cpu_read(input logic [7:0] a);
    cyc(0, 0, 0, 0, rnd38(), 1, 0, a, 32'h0, 4'h0);
  endtask

  logic [31:0] old_val;

  initial begin
    reset = 1'b1; jdo = '0; take_action_ocimem_a = 0; take_no_action_ocimem_a = 0;
    take_action_ocimem_b = 0; avs_address = 0; avs_read = 0; avs_write = 0;
    avs_writedata = 0; avs_byteenable = 0;
    busy = 0; p_wr = 0; p_addr = 0; p_data = 0;
    @(posedge clk); #1;
    do_rst();
    do_rst();

    for (int i = 0; i < 256; i++) cpu_write(8'(i), $urandom, 4'hF);

    // Address load only: no access, ready stays high.
    jt_a(1, 8'h10, 0, 0);
    check("load_no_busy", {31'b0, monitor_ready}, 32'd1);

    jt_b(32'hDEADBEEF);
    nop();
    jt_a(1, 8'h10, 1, 0);
    nop();
    nop();
    check("deadbeef", MonDReg, 32'hDEADBEEF);
    jt_na(); nop(); nop();
    check("next_0x11", MonDReg, m_mem[8'h11]);

    // Address wrap 0xFF -> 0x00.
    jt_a(1, 8'hFF, 0, 0);
    jt_b(32'h0000_0001);
    nop();
    jt_na(); nop(); nop();
    check("wrap_read0", MonDReg, m_mem[8'h00]);
    jt_na(); nop(); nop();
    check("wrap_read1", MonDReg, m_mem[8'h01]);
    jt_a(1, 8'hFF, 1, 0); nop(); nop();
    check("wrote_ff", MonDReg, 32'h0000_0001);

    // Dropped command sets the sticky error and has no effect.
    jt_a(1, 8'h40, 0, 0);
    jt_b(32'h0BADF00D);
    jt_a(1, 8'h55, 1, 1);
    check("drop_err", {31'b0, monitor_error}, 32'd1);
    jt_na(); nop(); nop();
    check("drop_noeffect", MonDReg, m_mem[8'h41]);
    jt_a(1, 8'h40, 1, 0); nop(); nop();
    check("drop_wr_ok", MonDReg, 32'h0BADF00D);
    check("err_sticky", {31'b0, monitor_error}, 32'd1);
    jt_a(0, 8'h00, 0, 1);
    check("err_clear", {31'b0, monitor_error}, 32'd0);

    // CPU partial write and JTAG read strobe in the same cycle.
    old_val = m_mem[8'h20];
    check("cpu_nostall", {31'b0, avs_waitrequest}, 32'd0);
    cyc(0, 1, 0, 0, mk_a(1, 8'h20, 1, 0), 0, 1, 8'h20, 32'hA5A5A5A5, 4'b0011);
    check("stall_t1", {31'b0, avs_waitrequest}, 32'd1);
    nop();
    check("stall_t2", {31'b0, avs_waitrequest}, 32'd1);
    nop();
    check("merge", MonDReg, {old_val[31:16], 16'hA5A5});
    check("stall_done", {31'b0, avs_waitrequest}, 32'd0);

    // Reset during JACC of a JTAG write abandons it.
    jt_a(1, 8'h30, 0, 0);
    old_val = m_mem[8'h30];
    jt_b(32'h12345678);
    do_rst();
    check("rst_mond", MonDReg, 32'h0);
    cpu_read(8'h30);
    check("rst_keep", avs_readdata, old_val);

    for (int i = 0; i < 600; i++) begin
      cyc(0, $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
          rnd38(), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          8'($urandom), $urandom, 4'($urandom));
    end
    nop(); nop(); nop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctest_nios_nios2_gen2_0_cpu_debug_ocimem.md
# ctest_nios_nios2_gen2_0_cpu_debug_ocimem

Debug monitor memory controller sitting directly downstream of the debug slave wrapper in the `clk` domain. It consumes the `take_action_ocimem_*` strobes and the `jdo` shift-register snapshot, and performs JTAG-initiated reads and writes on a 256x32 on-chip monitor RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper. The same RAM is also exposed to the CPU through an Avalon-MM slave port; JTAG has priority over the CPU.

## Interface
- `ADDR_W`, 8, word-address width; RAM depth is 2**ADDR_W; JTAG address field is `jdo[ADDR_W+25:26]`.
- `clk`  in  1  single system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  JTAG data snapshot; stable in any cycle that carries a strobe.
- `take_action_ocimem_a`  in  1  one-cycle pulse: address/control command.
- `take_no_action_ocimem_a`  in  1  one-cycle pulse: read-next command.
- `take_action_ocimem_b`  in  1  one-cycle pulse: write-data command.
- `MonDReg`  out  32  last JTAG read data.
- `monitor_ready`  out  1  high when no JTAG command is pending.
- `monitor_error`  out  1  sticky flag: a JTAG command was dropped.
- `avs_address`  in  ADDR_W  CPU word address.
- `avs_read`, `avs_write`  in  1  CPU request.
- `avs_writedata`  in  32  CPU write data.
- `avs_byteenable`  in  4  CPU byte lanes.
- `avs_readdata`  out  32  registered read data; fixed read latency 1.
- `avs_waitrequest`  out  1  stall; combinational from registered state only.

## Operation
- **Command decode.** A command is taken in any cycle with a strobe. If several strobes assert together, priority is ocimem_b > ocimem_a > no_action_a; only the winner is decoded.
  - ocimem_a:
    - `jdo[35]`=1 loads `MonAReg` from the address field.
    - `jdo[25]`=1 queues a read at the (new) `MonAReg`.
    - `jdo[24]`=1 clears `monitor_error`.
    - The address load and the error clear occur even when no read is queued.
  - no_action_a: queues a read at `MonAReg`.
  - ocimem_b: queues a write of `jdo[34:3]` at `MonAReg`; all 4 bytes are written.
- **Pending flag.** A queued access sets `jpend`; `monitor_ready` = ~`jpend`.
- **Dropped commands.** Any strobe arriving while `jpend`=1 is dropped entirely: no address load, no access, no error clear. `monitor_error` is set to 1.
- **FSM states:** IDLE, JACC, JCAP.
  - IDLE -> JACC on the edge where a command queues an access.
  - JACC, RAM addressed by `MonAReg`:
    - Write: RAM is written at end of cycle; `MonAReg`++, `jpend` cleared, -> IDLE.
    - Read: -> JCAP.
  - JCAP: `MonDReg` <= RAM data; `MonAReg`++, `jpend` cleared, -> IDLE.
- **Address arithmetic.** `MonAReg` is ADDR_W bits and wraps modulo 2**ADDR_W (255 -> 0).
- **CPU port.**
  - `avs_waitrequest` = (state != IDLE) | `jpend`.
  - A CPU request is accepted in any cycle with waitrequest=0.
  - Write commits at that edge, with byte enables honoured.
  - Read returns data on `avs_readdata` in the next cycle.
  - A read and a write asserted together: write wins; the read is ignored.
- **Same-cycle JTAG strobe and CPU access.** When a strobe and an accepted CPU access occur in the same IDLE cycle, the CPU access completes in that cycle and the JTAG access follows in the next cycle. The two never contend for the RAM.
- **RAM.** 256x32, single port, synchronous read. Contents are not reset.

## Timing
- **Reset values:** `MonAReg`=0, `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, `avs_readdata`=0, `avs_waitrequest`=0, state IDLE, `jpend`=0.
- **Reset mid-operation:** reset has priority in every state. An access in JACC/JCAP is abandoned; a write in JACC is not committed.
- **JTAG write** (strobe in cycle T):
  - T+1: JACC, `monitor_ready`=0.
  - `monitor_ready`=1 at T+2.
- **JTAG read** (strobe in cycle T):
  - T+1: JACC; T+2: JCAP.
  - `MonDReg` valid and `monitor_ready`=1 at T+3.
- **CPU stalls:** the CPU is stalled in T+1..T+1 (write) or T+1..T+2 (read).
- **CPU read latency:** accepted at T, data at T+1.
- **Back-to-back JTAG:** the next strobe is legal once `monitor_ready`=1.

## Test plan
- Reset, then ocimem_a with `jdo[35]`=1, addr=0x10 -> `MonAReg`=0x10; `monitor_ready` stays 1; no RAM access.
- ocimem_b data 0xDEADBEEF at 0x10, then ocimem_a addr=0x10 + read -> `MonDReg`=0xDEADBEEF at T+3; `MonAReg`=0x11.
- Load addr 0xFF, write 0x1, then no_action_a -> address wraps to 0x00; the read returns RAM[0x00]; `MonAReg`=0x01.
- Strobe at T, second strobe at T+1 -> `monitor_error`=1; second command has no effect; ocimem_a with `jdo[24]`=1 after ready -> error cleared.
- CPU write 0xA5A5A5A5 with byteenable 0b0011 to 0x20 in the same cycle as a JTAG read strobe for 0x20:
  - CPU accepted with no stall.
  - JTAG read returns 0x????A5A5 (upper bytes unchanged).
  - CPU stalled T+1..T+2.
- Assert reset during JACC of a JTAG write of 0x12345678 -> the RAM location keeps its old value; all outputs return to their reset values the next cycle.
